// File: rtl/ysyx_24080006_mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one bridge port, one access in flight; a watchdog errors out hung accesses.
// Latency: grant at T, mem_req_valid at T+1, response pulse one cycle after mem_rsp_valid; readies only in IDLE.
module ysyx_24080006_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_we,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rsp_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             own_lsu_q, own_lsu_d;
  logic             last_lsu_q, last_lsu_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [31:0]      ifu_rdata_q, ifu_rdata_d;
  logic             ifu_rsp_err_q, ifu_rsp_err_d;
  logic             lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [31:0]      lsu_rdata_q, lsu_rdata_d;
  logic             lsu_rsp_err_q, lsu_rsp_err_d;

  logic idle, grant_lsu, grant_ifu, rsp_done, timeout;

  // On contention the requester not granted last wins.
  assign idle      = (state_q == ST_IDLE);
  assign grant_lsu = idle && lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
  assign grant_ifu = idle && ifu_req_valid && !grant_lsu;
  assign rsp_done  = (state_q == ST_WAIT) && mem_rsp_valid;
  assign timeout   = (state_q != ST_IDLE) && (timer_q == TO_LAST);

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign ifu_req_ready = reset_n && grant_ifu;
  assign lsu_req_ready = reset_n && grant_lsu;

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign ifu_rsp_err   = ifu_rsp_err_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign lsu_rsp_err   = lsu_rsp_err_q;

  always_comb begin
    state_d         = state_q;
    own_lsu_d       = own_lsu_q;
    last_lsu_d      = last_lsu_q;
    timer_d         = timer_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    ifu_rsp_err_d   = ifu_rsp_err_q;
    lsu_rsp_valid_d = 1'b0;
    lsu_rdata_d     = lsu_rdata_q;
    lsu_rsp_err_d   = lsu_rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_lsu || grant_ifu) begin
          own_lsu_d  = grant_lsu;
          last_lsu_d = grant_lsu;
          addr_d     = grant_lsu ? lsu_addr : ifu_addr;
          we_d       = grant_lsu && lsu_we;
          wdata_d    = grant_lsu ? lsu_wdata : 32'h0;
          wstrb_d    = (grant_lsu && lsu_we) ? lsu_wstrb : 4'h0;
          timer_d    = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        timer_d = timer_q + CNT_W'(1);
        // A real response in the same cycle as the watchdog expiry takes precedence.
        if (rsp_done || timeout) begin
          state_d = ST_IDLE;
          if (own_lsu_q) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rdata_d     = rsp_done ? mem_rdata : 32'h0;
            lsu_rsp_err_d   = rsp_done ? mem_rsp_err : 1'b1;
          end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rdata_d     = rsp_done ? mem_rdata : 32'h0;
            ifu_rsp_err_d   = rsp_done ? mem_rsp_err : 1'b1;
          end
        end else if ((state_q == ST_ISSUE) && mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      own_lsu_q       <= 1'b0;
      last_lsu_q      <= 1'b0;
      timer_q         <= '0;
      addr_q          <= 32'h0;
      we_q            <= 1'b0;
      wdata_q         <= 32'h0;
      wstrb_q         <= 4'h0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rdata_q     <= 32'h0;
      ifu_rsp_err_q   <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rdata_q     <= 32'h0;
      lsu_rsp_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      own_lsu_q       <= own_lsu_d;
      last_lsu_q      <= last_lsu_d;
      timer_q         <= timer_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rdata_q     <= ifu_rdata_d;
      ifu_rsp_err_q   <= ifu_rsp_err_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rdata_q     <= lsu_rdata_d;
      lsu_rsp_err_q   <= lsu_rsp_err_d;
    end
  end

endmodule
